// File: rtl/pll_byte_tx.sv
// Word FIFO feeding a framing FSM: each 32-bit word leaves as
// HEADER followed by its four bytes, MSB first, on a valid/ready link.
module pll_byte_tx #(
   parameter int         DEPTH  = 4,
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic [31:0]                wr_data_i,
   input  logic                       wr_en_i,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o,
   output logic [7:0]                 data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic                       sof_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      B3,
      B2,
      B1,
      B0
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] count_d;
   logic [31:0]   hold_q;
   logic [31:0]   hold_d;
   logic [7:0]    data_d;
   logic          valid_d;
   logic          sof_d;
   logic          empty;
   logic          xfer;
   logic          push;
   logic          pop;

   assign empty = (level_o == '0);
   assign xfer  = valid_o & ready_i;
   assign push  = wr_en_i & ~full_o;

   // A word is popped only from a registered non-empty level, so
   // push and pop never race for the same slot.
   assign pop = ~empty &
                ((state_q == IDLE) | ((state_q == B0) & xfer));

   assign count_d = level_o + LW'(push) - LW'(pop);

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_o    <= '0;
         full_o     <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (wr_en_i && full_o) begin
            overflow_o <= 1'b1;
         end
         level_o <= count_d;
         full_o  <= (count_d == LW'(DEPTH));
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      data_d  = data_o;
      valid_d = valid_o;
      sof_d   = sof_o;
      if (pop) begin
         state_d = HDR;
         hold_d  = mem[rd_ptr_q];
         data_d  = HEADER;
         valid_d = 1'b1;
         sof_d   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               valid_d = 1'b0;
               sof_d   = 1'b0;
            end
            HDR: begin
               if (xfer) begin
                  state_d = B3;
                  data_d  = hold_q[31:24];
                  sof_d   = 1'b0;
               end
            end
            B3: begin
               if (xfer) begin
                  state_d = B2;
                  data_d  = hold_q[23:16];
               end
            end
            B2: begin
               if (xfer) begin
                  state_d = B1;
                  data_d  = hold_q[15:8];
               end
            end
            B1: begin
               if (xfer) begin
                  state_d = B0;
                  data_d  = hold_q[7:0];
               end
            end
            B0: begin
               if (xfer) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  sof_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               valid_d = 1'b0;
               sof_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         hold_q  <= '0;
         data_o  <= 8'h00;
         valid_o <= 1'b0;
         sof_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         data_o  <= data_d;
         valid_o <= valid_d;
         sof_o   <= sof_d;
      end
   end

endmodule

// File: tb/tb_pll_byte_tx.sv
// Directed and table-driven checks for pll_byte_tx framing,
// stall, overflow, reset and pointer wrap behaviour.
module tb_pll_byte_tx;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic [31:0]   wr_data_i = '0;
   logic          wr_en_i = 1'b0;
   logic          full_o;
   logic [LW-1:0] level_o;
   logic          overflow_o;
   logic [7:0]    data_o;
   logic          valid_o;
   logic          ready_i = 1'b0;
   logic          sof_o;

   int checks = 0;
   int errors = 0;
   logic [8:0] rxq [$];

   pll_byte_tx #(.DEPTH(DEPTH), .HEADER(8'hA5)) dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .wr_data_i  (wr_data_i),
      .wr_en_i    (wr_en_i),
      .full_o     (full_o),
      .level_o    (level_o),
      .overflow_o (overflow_o),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .sof_o      (sof_o)
   );

   always #5 clk_i = ~clk_i;

   // Every accepted byte, stored as {sof, data}.
   always @(posedge clk_i) begin
      if (rstn_i && valid_o && ready_i) begin
         rxq.push_back({sof_o, data_o});
      end
   end

   typedef struct {
      logic          wr;
      logic [31:0]   wd;
      logic          rdy;
      logic          v;
      logic [7:0]    d;
      logic          s;
      logic [LW-1:0] lvl;
      logic          full;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_frames(input string name,
                                input logic [31:0] w [$],
                                input int budget);
      logic [8:0] exp [$];
      int n;
      for (int i = 0; i < w.size(); i++) begin
         exp.push_back({1'b1, 8'hA5});
         exp.push_back({1'b0, w[i][31:24]});
         exp.push_back({1'b0, w[i][23:16]});
         exp.push_back({1'b0, w[i][15:8]});
         exp.push_back({1'b0, w[i][7:0]});
      end
      for (int c = 0; c < budget && rxq.size() < exp.size(); c++) begin
         tick();
      end
      chk({name, "_count"}, rxq.size(), exp.size());
      n = (rxq.size() < exp.size()) ? rxq.size() : exp.size();
      for (int i = 0; i < n; i++) begin
         if (rxq[i] !== exp[i]) begin
            chk($sformatf("%s_byte%0d", name, i), rxq[i], exp[i]);
         end else begin
            checks++;
         end
      end
   endtask

   initial begin
      logic [31:0] words [$];
      logic [7:0]  b2b [10];
      int          sent;
      int          cyc;
      int          bad;

      tbl[0]  = '{1'b1, 32'h12345678, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0};
      tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hA5, 1'b1, 3'd0, 1'b0};
      tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h12, 1'b0, 3'd0, 1'b0};
      tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h34, 1'b0, 3'd0, 1'b0};
      tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h34, 1'b0, 3'd0, 1'b0};
      tbl[5]  = '{1'b1, 32'hAABBCCDD, 1'b0, 1'b1, 8'h34, 1'b0, 3'd1, 1'b0};
      tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h34, 1'b0, 3'd1, 1'b0};
      tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h56, 1'b0, 3'd1, 1'b0};
      tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h78, 1'b0, 3'd1, 1'b0};
      tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hA5, 1'b1, 3'd0, 1'b0};
      tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hAA, 1'b0, 3'd0, 1'b0};
      tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hBB, 1'b0, 3'd0, 1'b0};
      tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hCC, 1'b0, 3'd0, 1'b0};
      tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hDD, 1'b0, 3'd0, 1'b0};
      tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};

      // Reset state
      #12;
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 8'h00);
      chk("rst_sof", sof_o, 0);
      chk("rst_level", level_o, 0);
      chk("rst_full", full_o, 0);
      chk("rst_ovf", overflow_o, 0);
      @(posedge clk_i);
      #1 rstn_i = 1'b1;
      tick();

      // Single frame, stall on 0x34, write during transmission
      for (int i = 0; i < 15; i++) begin
         wr_en_i   = tbl[i].wr;
         wr_data_i = tbl[i].wd;
         ready_i   = tbl[i].rdy;
         tick();
         chk($sformatf("tbl%0d_valid", i), valid_o, tbl[i].v);
         chk($sformatf("tbl%0d_sof", i), sof_o, tbl[i].s);
         chk($sformatf("tbl%0d_level", i), level_o, tbl[i].lvl);
         chk($sformatf("tbl%0d_full", i), full_o, tbl[i].full);
         if (tbl[i].v) begin
            chk($sformatf("tbl%0d_data", i), data_o, tbl[i].d);
         end
      end
      wr_en_i = 1'b0;
      tick();

      // Back-to-back frames with no gap
      b2b = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
              8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
      ready_i   = 1'b1;
      wr_en_i   = 1'b1;
      wr_data_i = 32'hDEADBEEF;
      tick();
      chk("b2b_pre_valid", valid_o, 0);
      wr_data_i = 32'h01020304;
      tick();
      wr_en_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("b2b%0d_valid", i), valid_o, 1);
         chk($sformatf("b2b%0d_data", i), data_o, b2b[i]);
         chk($sformatf("b2b%0d_sof", i), sof_o, (i % 5) == 0);
         tick();
      end
      chk("b2b_end_valid", valid_o, 0);

      // Overflow with ready low, then drain
      ready_i = 1'b0;
      words = {32'h10000001, 32'h20000002, 32'h30000003,
               32'h40000004, 32'h50000005, 32'h60000006};
      for (int k = 0; k < 6; k++) begin
         wr_en_i   = 1'b1;
         wr_data_i = words[k];
         tick();
         if (k == 4) begin
            chk("ovf_full5", full_o, 1);
            chk("ovf_flag5", overflow_o, 0);
         end
      end
      wr_en_i = 1'b0;
      chk("ovf_full", full_o, 1);
      chk("ovf_level", level_o, 4);
      chk("ovf_flag", overflow_o, 1);
      chk("ovf_valid", valid_o, 1);
      chk("ovf_hdr", data_o, 8'hA5);
      rxq.delete();
      void'(words.pop_back());
      ready_i = 1'b1;
      expect_frames("ovf_drain", words, 100);
      tick();
      chk("ovf_sticky", overflow_o, 1);
      chk("ovf_empty", level_o, 0);

      // Reset during B2 with a word queued behind
      wr_en_i   = 1'b1;
      wr_data_i = 32'h11223344;
      tick();
      wr_data_i = 32'h55667788;
      tick();
      wr_en_i = 1'b0;
      tick();
      tick();
      chk("rstmid_b2", data_o, 8'h22);
      chk("rstmid_lvl", level_o, 1);
      #2 rstn_i = 1'b0;
      #1;
      chk("rstmid_valid", valid_o, 0);
      chk("rstmid_data", data_o, 8'h00);
      chk("rstmid_sof", sof_o, 0);
      chk("rstmid_level", level_o, 0);
      chk("rstmid_ovf", overflow_o, 0);
      @(posedge clk_i);
      #1 rstn_i = 1'b1;
      rxq.delete();
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (valid_o) bad++;
      end
      chk("rstmid_quiet", bad, 0);
      wr_en_i   = 1'b1;
      wr_data_i = 32'h9ABCDEF0;
      tick();
      wr_en_i = 1'b0;
      chk("rstmid_lat1", valid_o, 0);
      tick();
      chk("rstmid_lat2", valid_o, 1);
      words = {32'h9ABCDEF0};
      expect_frames("rstmid_frame", words, 20);
      tick();

      // Random ready, 14 words across pointer wrap
      rxq.delete();
      words.delete();
      sent = 0;
      cyc  = 0;
      while (cyc < 3000 && rxq.size() < 70) begin
         ready_i = 1'($urandom_range(0, 1));
         wr_en_i = 1'b0;
         if (sent < 14 && !full_o && $urandom_range(0, 2) != 0) begin
            wr_en_i   = 1'b1;
            wr_data_i = $urandom;
            words.push_back(wr_data_i);
            sent++;
         end
         tick();
         cyc++;
      end
      wr_en_i = 1'b0;
      ready_i = 1'b1;
      chk("rand_sent", sent, 14);
      expect_frames("rand", words, 50);
      chk("rand_ovf", overflow_o, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
